// File: rtl/reward_pkg.sv
// reward_pkg: packet types, request bundle and index helpers.
// Build option REWARD_DEDUP_EN drops duplicate requesters.
package reward_pkg;

  localparam int REQ_W = 16;

  typedef enum logic [2:0] {
    HEARTBEAT    = 3'b000,
    REWARD       = 3'b010,
    DATA         = 3'b011,
    LOW_E_REWARD = 3'b101,
    INVALID      = 3'b111
  } pkt_type_e;

  typedef struct packed {
    logic [REQ_W-1:0] src;
    logic [REQ_W-1:0] qv;
  } reward_req_t;

  // Index value meaning "requester not in table".
  function automatic int nt_sentinel(input int depth);
    return depth;
  endfunction

endpackage

// File: rtl/reward_req_fifo.sv
// reward_req_fifo: circular request buffer, wrap-bit pointers.
// REWARD_DEDUP_EN: drop a push whose key is queued or in flight.
module reward_req_fifo
  import reward_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
`ifdef REWARD_DEDUP_EN
  input  logic          busy_i,
  input  logic [DW/2-1:0] busy_key_i,
`endif
  output logic [DW-1:0] data_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic          dup, acc;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o  = mem_q[rd_q[AW-1:0]];

`ifdef REWARD_DEDUP_EN
  localparam int KW = DW / 2;
  logic [PW-1:0] cnt;
  assign cnt = wr_q - rd_q;

  // Match the incoming key against live entries and the in-flight one.
  always_comb begin
    dup = busy_i & (busy_key_i == data_i[DW-1 -: KW]);
    for (int i = 0; i < DEPTH; i++) begin
      if ((PW'(i) < cnt) &&
          (mem_q[AW'(rd_q[AW-1:0] + AW'(i))][DW-1 -: KW]
           == data_i[DW-1 -: KW]))
        dup = 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // A pop in the same cycle frees the slot for a push.
  assign acc = push_i & (~full_o | pop_i) & ~dup;

  // Pointer update.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (acc)   wr_q <= wr_q + PW'(1);
      if (pop_i) rd_q <= rd_q + PW'(1);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (acc) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/reward_engine.sv
// reward_engine: queued reward requests, table scan, Q update, emit.
// Build option REWARD_DEDUP_EN drops duplicate requesters.
module reward_engine
  import reward_pkg::*;
#(
  parameter int WORD_WIDTH  = 16,
  parameter int Q_DEPTH     = 4,
  parameter int NT_DEPTH    = 32,
  parameter int ALPHA_SHIFT = 2,
  parameter int TS_W        = 6,
  localparam int NTI_W      = $clog2(NT_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  iAmDestination,
  input  logic [2:0]            fPacketType,
  input  logic [WORD_WIDTH-1:0] fSourceID,
  input  logic [WORD_WIDTH-1:0] fQValue,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] myEnergy,
  input  logic [WORD_WIDTH-1:0] myQValue,
  input  logic [WORD_WIDTH-1:0] hopsFromSink,
  input  logic                  low_E,
  input  logic                  okToSend,
  input  logic [NTI_W-1:0]      neighborCount,
  input  logic [WORD_WIDTH-1:0] mNodeID,
  output logic [NTI_W-1:0]      nTableIndex_reward,
  output logic                  rValid,
  output logic [2:0]            rPacketType,
  output logic [WORD_WIDTH-1:0] rSourceID,
  output logic [WORD_WIDTH-1:0] rDestinationID,
  output logic [WORD_WIDTH-1:0] rQValue,
  output logic [WORD_WIDTH-1:0] rEnergyLeft,
  output logic [WORD_WIDTH-1:0] rSourceHops,
  output logic [TS_W-1:0]       rTimeslot,
  output logic                  reward_done,
  output logic                  qFull
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_POP  = 3'd1;
  localparam logic [2:0] S_SCAN = 3'd2;
  localparam logic [2:0] S_UPD  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_EMIT = 3'd5;

  localparam logic [NTI_W-1:0] NT_SENT =
    NTI_W'(nt_sentinel(NT_DEPTH));

  localparam int W = WORD_WIDTH;

  logic [2:0]       state_q, state_d;
  logic             ph_q, ph_d;
  logic [NTI_W-1:0] idx_q, idx_d;
  logic [W-1:0]     src_q, src_d;
  logic [W-1:0]     fq_q, fq_d;
  logic [W-1:0]     upd_q, upd_d;
  logic             lowe_q, lowe_d;
  logic [TS_W-1:0]  slot_q, slot_d;
  logic             rvalid_q, rvalid_d;
  logic [2:0]       rtype_q, rtype_d;
  logic [W-1:0]     rsrc_q, rsrc_d;
  logic [W-1:0]     rdst_q, rdst_d;
  logic [W-1:0]     rqv_q, rqv_d;
  logic [W-1:0]     ren_q, ren_d;
  logic [W-1:0]     rhops_q, rhops_d;
  logic [TS_W-1:0]  rts_q, rts_d;

  logic             push, pop, empty, full;
  logic [2*W-1:0]   head;
  logic             q_ge;
  logic [W-1:0]     q_diff, q_step;

  assign push = en & ((fPacketType == HEARTBEAT) |
                      ((fPacketType == DATA) & iAmDestination));
  assign pop  = (state_q == S_IDLE) & ~empty;

  reward_req_fifo #(
    .DW    (2 * W),
    .DEPTH (Q_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_i      (nrst),
    .push_i     (push),
    .data_i     ({fSourceID, fQValue}),
    .pop_i      (pop),
`ifdef REWARD_DEDUP_EN
    .busy_i     (state_q != S_IDLE),
    .busy_key_i (src_q),
`endif
    .data_o     (head),
    .empty_o    (empty),
    .full_o     (full)
  );

  // Shift-based step toward the requester's Q-value.
  assign q_ge   = fq_q >= myQValue;
  assign q_diff = q_ge ? fq_q - myQValue : myQValue - fq_q;
  assign q_step = q_diff >> ALPHA_SHIFT;

  // Next-state and datapath for the request sequencer.
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    idx_d    = idx_q;
    src_d    = src_q;
    fq_d     = fq_q;
    upd_d    = upd_q;
    lowe_d   = lowe_q;
    slot_d   = slot_q;
    rvalid_d = 1'b0;
    rtype_d  = rtype_q;
    rsrc_d   = rsrc_q;
    rdst_d   = rdst_q;
    rqv_d    = rqv_q;
    ren_d    = ren_q;
    rhops_d  = rhops_q;
    rts_d    = rts_q;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          src_d   = head[2*W-1:W];
          fq_d    = head[W-1:0];
          state_d = S_POP;
        end
      end
      S_POP: begin
        ph_d = 1'b0;
        if (neighborCount == '0) begin
          idx_d   = NT_SENT;
          state_d = S_UPD;
        end else begin
          idx_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          if (mNodeID == src_q) begin
            state_d = S_UPD;
          end else if (idx_q + NTI_W'(1) == neighborCount) begin
            idx_d   = NT_SENT;
            state_d = S_UPD;
          end else begin
            idx_d = idx_q + NTI_W'(1);
          end
        end
      end
      S_UPD: begin
        upd_d   = q_ge ? myQValue + q_step : myQValue - q_step;
        lowe_d  = low_E;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (okToSend) begin
          rvalid_d = 1'b1;
          rtype_d  = lowe_q ? LOW_E_REWARD : HEARTBEAT;
          rsrc_d   = myNodeID;
          rdst_d   = src_q;
          rqv_d    = upd_q;
          ren_d    = myEnergy;
          rhops_d  = hopsFromSink;
          rts_d    = slot_q;
          slot_d   = slot_q + TS_W'(1);
          state_d  = S_EMIT;
        end
      end
      S_EMIT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any request in progress.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q  <= S_IDLE;
      ph_q     <= 1'b0;
      idx_q    <= NT_SENT;
      src_q    <= '0;
      fq_q     <= '0;
      upd_q    <= '0;
      lowe_q   <= 1'b0;
      slot_q   <= '0;
      rvalid_q <= 1'b0;
      rtype_q  <= '0;
      rsrc_q   <= '0;
      rdst_q   <= '0;
      rqv_q    <= '0;
      ren_q    <= '0;
      rhops_q  <= '0;
      rts_q    <= '0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      idx_q    <= idx_d;
      src_q    <= src_d;
      fq_q     <= fq_d;
      upd_q    <= upd_d;
      lowe_q   <= lowe_d;
      slot_q   <= slot_d;
      rvalid_q <= rvalid_d;
      rtype_q  <= rtype_d;
      rsrc_q   <= rsrc_d;
      rdst_q   <= rdst_d;
      rqv_q    <= rqv_d;
      ren_q    <= ren_d;
      rhops_q  <= rhops_d;
      rts_q    <= rts_d;
    end
  end

  assign nTableIndex_reward = idx_q;
  assign rValid             = rvalid_q;
  assign reward_done        = rvalid_q;
  assign rPacketType        = rtype_q;
  assign rSourceID          = rsrc_q;
  assign rDestinationID     = rdst_q;
  assign rQValue            = rqv_q;
  assign rEnergyLeft        = ren_q;
  assign rSourceHops        = rhops_q;
  assign rTimeslot          = rts_q;
  assign qFull              = full;

endmodule

// File: tb/tb_reward_engine.sv
// tb_reward_engine: directed requests, scoreboard-checked emissions.
// Honours REWARD_DEDUP_EN when choosing duplicate expectations.
module tb_reward_engine;

  logic        clk = 1'b0;
  logic        nrst, en, iAmDestination, low_E, okToSend;
  logic [2:0]  fPacketType;
  logic [15:0] fSourceID, fQValue, myNodeID, myEnergy;
  logic [15:0] myQValue, hopsFromSink, mNodeID;
  logic [5:0]  neighborCount, nTableIndex_reward;
  logic        rValid, reward_done, qFull;
  logic [2:0]  rPacketType;
  logic [15:0] rSourceID, rDestinationID, rQValue;
  logic [15:0] rEnergyLeft, rSourceHops;
  logic [5:0]  rTimeslot;

  typedef struct {
    logic [15:0] dst;
    logic [15:0] q;
    logic [2:0]  typ;
    logic [5:0]  ts;
    logic [5:0]  idx;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          total = 0;
  int          bad = 0;
  int          emits = 0;
  int          exp_emits = 0;
  logic [5:0]  nslot = '0;
  logic [15:0] nt [32];

  always #5 clk = ~clk;

  reward_engine dut (
    .clk                (clk),
    .nrst               (nrst),
    .en                 (en),
    .iAmDestination     (iAmDestination),
    .fPacketType        (fPacketType),
    .fSourceID          (fSourceID),
    .fQValue            (fQValue),
    .myNodeID           (myNodeID),
    .myEnergy           (myEnergy),
    .myQValue           (myQValue),
    .hopsFromSink       (hopsFromSink),
    .low_E              (low_E),
    .okToSend           (okToSend),
    .neighborCount      (neighborCount),
    .mNodeID            (mNodeID),
    .nTableIndex_reward (nTableIndex_reward),
    .rValid             (rValid),
    .rPacketType        (rPacketType),
    .rSourceID          (rSourceID),
    .rDestinationID     (rDestinationID),
    .rQValue            (rQValue),
    .rEnergyLeft        (rEnergyLeft),
    .rSourceHops        (rSourceHops),
    .rTimeslot          (rTimeslot),
    .reward_done        (reward_done),
    .qFull              (qFull)
  );

  // Neighbour table: read data appears one cycle after the index.
  always @(posedge clk)
    mNodeID <= (nTableIndex_reward < 6'd32) ?
               nt[nTableIndex_reward[4:0]] : 16'h0000;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every emission is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!nrst && rValid) begin
      emits++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_emit: got dest %0h want none",
                 rDestinationID);
      end else begin
        cur = sb.pop_front();
        chk("dest", rDestinationID, cur.dst);
        chk("qvalue", rQValue, cur.q);
        chk("ptype", rPacketType, cur.typ);
        chk("timeslot", rTimeslot, cur.ts);
        chk("index", nTableIndex_reward, cur.idx);
        chk("srcid", rSourceID, 16'h00AA);
        chk("energy", rEnergyLeft, 16'h1234);
        chk("hops", rSourceHops, 16'h0003);
        chk("done", reward_done, 1'b1);
      end
    end
  end

  task automatic expect_rw(input logic [15:0] d, input logic [15:0] q,
                           input logic le, input logic [5:0] idx);
    exp_t e;
    e.dst = d;
    e.q   = q;
    e.typ = le ? 3'b101 : 3'b000;
    e.ts  = nslot;
    e.idx = idx;
    sb.push_back(e);
    nslot = nslot + 6'd1;
    exp_emits++;
  endtask

  task automatic send(input logic [15:0] s, input logic [15:0] q,
                      input logic [2:0] t, input logic d);
    @(negedge clk);
    en = 1'b1;
    fSourceID = s;
    fQValue = q;
    fPacketType = t;
    iAmDestination = d;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: pending %0d want 0", nm, sb.size());
      sb.delete();
    end
    repeat (4) @(negedge clk);
    chk({nm, "_emits"}, emits, exp_emits);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit hit, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b1; en = 1'b0; iAmDestination = 1'b0; low_E = 1'b0;
    okToSend = 1'b0; fPacketType = 3'b111; fSourceID = '0;
    fQValue = '0; myNodeID = 16'h00AA; myEnergy = 16'h1234;
    myQValue = '0; hopsFromSink = 16'h0003; neighborCount = '0;
    for (int i = 0; i < 32; i++) nt[i] = 16'hF000 + 16'(i);
    nt[0] = 16'h0010; nt[1] = 16'h0020; nt[2] = 16'h0030;
    nt[3] = 16'h0005; nt[4] = 16'h0040;
    repeat (3) @(negedge clk);
    chk("rst_valid", rValid, 1'b0);
    chk("rst_done", reward_done, 1'b0);
    chk("rst_full", qFull, 1'b0);
    chk("rst_index", nTableIndex_reward, 6'd32);
    chk("rst_q", rQValue, 16'h0);
    chk("rst_ts", rTimeslot, 6'd0);
    chk("rst_dest", rDestinationID, 16'h0);
    chk("rst_src", rSourceID, 16'h0);
    nrst = 1'b0;

    // Basic request, table miss.
    neighborCount = 6'd5; okToSend = 1'b1; myQValue = 16'h0000;
    expect_rw(16'h0001, 16'h0010, 1'b0, 6'd32);
    send(16'h0001, 16'h0040, 3'b000, 1'b0);
    drain("basic");

    // DATA to us, hit at index 3, Q moves down.
    myQValue = 16'h0100;
    expect_rw(16'h0005, 16'h00C0, 1'b0, 6'd3);
    send(16'h0005, 16'h0000, 3'b011, 1'b1);
    drain("hit3");

    // Packets that must not enqueue.
    send(16'h0009, 16'h0010, 3'b011, 1'b0);
    send(16'h0009, 16'h0010, 3'b111, 1'b1);
    send(16'h0009, 16'h0010, 3'b010, 1'b1);
    repeat (40) @(negedge clk);
    chk("ignored_emits", emits, exp_emits);

    // Empty table, low energy.
    neighborCount = 6'd0; low_E = 1'b1;
    expect_rw(16'h0030, 16'h0100, 1'b1, 6'd32);
    send(16'h0030, 16'h0100, 3'b000, 1'b0);
    drain("empty_tbl");
    low_E = 1'b0;

    // Fill the queue behind a request stalled in WAIT.
    neighborCount = 6'd5; myQValue = 16'h0040; okToSend = 1'b0;
    expect_rw(16'h0021, 16'h0050, 1'b0, 6'd32);
    send(16'h0021, 16'h0080, 3'b000, 1'b0);
    repeat (30) @(negedge clk);
    chk("stall_full", qFull, 1'b0);
    expect_rw(16'h0022, 16'h0030, 1'b0, 6'd32);
    expect_rw(16'h0030, 16'h0040, 1'b0, 6'd2);
    expect_rw(16'h0024, 16'h0440, 1'b0, 6'd32);
    expect_rw(16'h0025, 16'h402F, 1'b0, 6'd32);
    send(16'h0022, 16'h0000, 3'b000, 1'b0);
    send(16'h0030, 16'h0040, 3'b000, 1'b0);
    send(16'h0024, 16'h1040, 3'b000, 1'b0);
    chk("not_full3", qFull, 1'b0);
    send(16'h0025, 16'hFFFF, 3'b000, 1'b0);
    chk("full4", qFull, 1'b1);
    send(16'h0026, 16'h0000, 3'b000, 1'b0);
    chk("full_drop", qFull, 1'b1);
    repeat (10) @(negedge clk);
    chk("wait_hold", emits, exp_emits - 5);
    okToSend = 1'b1;
    drain("full");
    chk("drained_full", qFull, 1'b0);

    // Duplicate requester.
    expect_rw(16'h0007, 16'h0032, 1'b0, 6'd32);
`ifndef REWARD_DEDUP_EN
    expect_rw(16'h0007, 16'h0032, 1'b0, 6'd32);
`endif
    send(16'h0007, 16'h0008, 3'b000, 1'b0);
    send(16'h0007, 16'h0008, 3'b000, 1'b0);
    drain("dup");

    // Reset while a request waits for the grant.
    okToSend = 1'b0;
    send(16'h0050, 16'h0010, 3'b000, 1'b0);
    repeat (20) @(negedge clk);
    send(16'h0051, 16'h0010, 3'b000, 1'b0);
    send(16'h0052, 16'h0010, 3'b000, 1'b0);
    nrst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", rValid, 1'b0);
    chk("mid_rst_full", qFull, 1'b0);
    chk("mid_rst_index", nTableIndex_reward, 6'd32);
    chk("mid_rst_q", rQValue, 16'h0);
    chk("mid_rst_dest", rDestinationID, 16'h0);
    nrst = 1'b0;
    nslot = '0;
    okToSend = 1'b1;
    repeat (40) @(negedge clk);
    chk("mid_rst_emits", emits, exp_emits);

    // 65 emissions: the last one wraps the timeslot back to 0.
    neighborCount = 6'd0; myQValue = 16'h0000;
    for (int i = 0; i < 65; i++) begin
      expect_rw(16'h0100 + 16'(i), 16'(i), 1'b0, 6'd32);
      send(16'h0100 + 16'(i), 16'(i * 4), 3'b000, 1'b0);
      drain("wrap");
    end
    chk("wrap_ts", rTimeslot, 6'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
